// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-FF input synchroniser and mid-bit sampling.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity errors.
module uart_rx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       parity_err
);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  state_t        state_q, state_d;
  logic [1:0]    sync_q;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d, data_q, data_d;
  logic          done_q, done_d, ferr_q, ferr_d;
  logic          rxd_s, baud_last, baud_half;
  assign rxd_s     = sync_q[1];
  assign baud_last = baud_q == CW'(CLKS_PER_BIT - 1);
  assign baud_half = baud_q == CW'(HALF_BIT - 1);
  assign data_out  = data_q;
  assign rx_done   = done_q;
  assign rx_busy   = state_q != IDLE;
  assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, perr_q, perr_d;
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q;
`endif
    case (state_q)
      IDLE: begin
        baud_d  = '0;
        state_d = rxd_s ? IDLE : START;
      end
      START: begin
        baud_d = baud_half ? '0 : baud_q + 1'b1;
        bit_d  = '0;
        if (baud_half) state_d = rxd_s ? IDLE : DATA;
      end
      DATA: begin
        baud_d = baud_last ? '0 : baud_q + 1'b1;
        if (baud_last) begin
          shift_d[bit_q] = rxd_s;
          bit_d          = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_q == 3'd7) state_d = PARITY;
`else
          if (bit_q == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        baud_d = baud_last ? '0 : baud_q + 1'b1;
        if (baud_last) begin
          par_d   = (^shift_q) ^ rxd_s;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        baud_d = baud_last ? '0 : baud_q + 1'b1;
        if (baud_last) begin
          data_d  = shift_q;
          done_d  = 1'b1;
          ferr_d  = ~rxd_s;
`ifdef UART_RX_PARITY_EN
          perr_d  = par_q;
`endif
          // Leaving at the stop-bit centre leaves half a bit to catch the next start edge.
          state_d = rxd_s ? IDLE : BREAK;
        end
      end
      BREAK: state_d = rxd_s ? IDLE : BREAK;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], rxd};
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx at 16 clks/bit, checked against hand-computed bytes.
module tb_uart_rx;
  localparam int C = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 2 + C / 2 + 10 * C;
`else
  localparam int LAT = 2 + C / 2 + 9 * C;
`endif
  logic       clk = 1'b0;
  logic       reset, rxd;
  logic [7:0] data_out;
  logic       rx_done, rx_busy, frame_err, parity_err;
  int         tests = 0, fails = 0, n_done = 0;
  logic [7:0] log_d [4];
  logic       log_fe [4];
  longint     t_fall, t_done;
  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(reset), .rxd(rxd), .data_out(data_out), .rx_done(rx_done),
    .rx_busy(rx_busy), .frame_err(frame_err), .parity_err(parity_err)
  );
  always #10 clk = ~clk;
  always @(posedge clk) if (rx_done) begin
    log_d[n_done % 4]  = data_out;
    log_fe[n_done % 4] = frame_err;
    t_done = $time;
    n_done++;
  end
  task automatic send_bit(input logic b);
    rxd = b;
    repeat (C) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip);
    logic pb;
    pb = (^d) ^ pflip;
    t_fall = $time;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(pb);
`endif
    send_bit(stop);
  endtask
  task automatic test_reset;
    reset = 1'b1;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    tests += 5;
    if (data_out !== 8'h00) begin fails++; $display("FAIL reset data_out got %h want 00", data_out); end
    if (rx_done !== 1'b0) begin fails++; $display("FAIL reset rx_done got %b want 0", rx_done); end
    if (rx_busy !== 1'b0) begin fails++; $display("FAIL reset rx_busy got %b want 0", rx_busy); end
    if (frame_err !== 1'b0) begin fails++; $display("FAIL reset frame_err got %b want 0", frame_err); end
    if (parity_err !== 1'b0) begin fails++; $display("FAIL reset parity_err got %b want 0", parity_err); end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  task automatic test_single;
    int n0, lat;
    n0 = n_done;
    send_frame(8'hAA, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    lat = int'((t_done - t_fall - 10) / 20);
    tests += 6;
    if (n_done - n0 != 1) begin fails++; $display("FAIL single count got %0d want 1", n_done - n0); end
    if (log_d[n0 % 4] !== 8'hAA) begin fails++; $display("FAIL single data got %h want aa", log_d[n0 % 4]); end
    if (frame_err !== 1'b0) begin fails++; $display("FAIL single frame_err got %b want 0", frame_err); end
    if (parity_err !== 1'b0) begin fails++; $display("FAIL single parity_err got %b want 0", parity_err); end
    if (rx_busy !== 1'b0) begin fails++; $display("FAIL single rx_busy got %b want 0", rx_busy); end
    if (lat < LAT - 1 || lat > LAT + 1) begin fails++; $display("FAIL single latency got %0d want %0d+-1", lat, LAT); end
  endtask
  task automatic test_back_to_back;
    int n0;
    n0 = n_done;
    send_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'h0F, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    tests += 3;
    if (n_done - n0 != 2) begin fails++; $display("FAIL b2b count got %0d want 2", n_done - n0); end
    if (log_d[n0 % 4] !== 8'h55) begin fails++; $display("FAIL b2b first got %h want 55", log_d[n0 % 4]); end
    if (log_d[(n0 + 1) % 4] !== 8'h0F) begin fails++; $display("FAIL b2b second got %h want 0f", log_d[(n0 + 1) % 4]); end
  endtask
  task automatic test_glitch;
    int n0;
    n0 = n_done;
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    tests += 3;
    if (rx_busy !== 1'b1) begin fails++; $display("FAIL glitch busy_high got %b want 1", rx_busy); end
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    if (rx_busy !== 1'b0) begin fails++; $display("FAIL glitch busy_low got %b want 0", rx_busy); end
    if (n_done != n0) begin fails++; $display("FAIL glitch count got %0d want 0", n_done - n0); end
  endtask
  task automatic test_break;
    int n0;
    n0 = n_done;
    send_frame(8'h3C, 1'b0, 1'b0);
    rxd = 1'b0;
    repeat (40) @(negedge clk);
    tests += 9;
    if (n_done - n0 != 1) begin fails++; $display("FAIL break count got %0d want 1", n_done - n0); end
    if (log_d[n0 % 4] !== 8'h3C) begin fails++; $display("FAIL break data got %h want 3c", log_d[n0 % 4]); end
    if (log_fe[n0 % 4] !== 1'b1) begin fails++; $display("FAIL break fe_at_done got %b want 1", log_fe[n0 % 4]); end
    if (frame_err !== 1'b1) begin fails++; $display("FAIL break frame_err_held got %b want 1", frame_err); end
    if (rx_busy !== 1'b1) begin fails++; $display("FAIL break busy got %b want 1", rx_busy); end
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    if (n_done - n0 != 1 || rx_busy !== 1'b0) begin
      fails++; $display("FAIL break release count %0d busy %b want 1 0", n_done - n0, rx_busy);
    end
    send_frame(8'h5A, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    if (n_done - n0 != 2) begin fails++; $display("FAIL break next_count got %0d want 2", n_done - n0); end
    if (data_out !== 8'h5A) begin fails++; $display("FAIL break next_data got %h want 5a", data_out); end
    if (frame_err !== 1'b0) begin fails++; $display("FAIL break next_fe got %b want 0", frame_err); end
  endtask
  task automatic test_reset_mid;
    int n0;
    n0 = n_done;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (C / 2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests += 7;
    if (data_out !== 8'h00) begin fails++; $display("FAIL rstmid data_out got %h want 00", data_out); end
    if (rx_busy !== 1'b0) begin fails++; $display("FAIL rstmid rx_busy got %b want 0", rx_busy); end
    if (frame_err !== 1'b0 || rx_done !== 1'b0) begin
      fails++; $display("FAIL rstmid flags fe %b done %b want 0 0", frame_err, rx_done);
    end
    reset = 1'b0;
    repeat (40) @(negedge clk);
    if (n_done != n0) begin fails++; $display("FAIL rstmid count got %0d want 0", n_done - n0); end
    send_frame(8'h81, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    if (n_done - n0 != 1) begin fails++; $display("FAIL rstmid next_count got %0d want 1", n_done - n0); end
    if (data_out !== 8'h81) begin fails++; $display("FAIL rstmid next_data got %h want 81", data_out); end
    if (frame_err !== 1'b0) begin fails++; $display("FAIL rstmid next_fe got %b want 0", frame_err); end
  endtask
`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    tests += 3;
    if (parity_err !== 1'b0) begin fails++; $display("FAIL parity good got %b want 0", parity_err); end
    if (data_out !== 8'h07) begin fails++; $display("FAIL parity data got %h want 07", data_out); end
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    if (parity_err !== 1'b1) begin fails++; $display("FAIL parity bad got %b want 1", parity_err); end
  endtask
`endif
  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_break;
    test_reset_mid;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
